// File: rtl/chip8_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : chip8_pkg                                                       |
// | Purpose  : Shared types and the physical keypad layout for the CHIP-8      |
// |            keypad scanner.                                                 |
// | Contents : key_idx_t - 4-bit CHIP-8 key index                              |
// |            KEY_TABLE - (row, col) -> key map, position p = row*4 + col     |
// |            key_at()  - look up the key at a physical position              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package chip8_pkg;

  typedef logic [3:0] key_idx_t;

  // Nibble p holds the key at position p = row*4 + col. Rows top-down:
  //   r0 = 1 2 3 C   r1 = 4 5 6 D   r2 = 7 8 9 E   r3 = A 0 B F
  localparam logic [63:0] KEY_TABLE = {
    4'hF, 4'hB, 4'h0, 4'hA,
    4'hE, 4'h9, 4'h8, 4'h7,
    4'hD, 4'h6, 4'h5, 4'h4,
    4'hC, 4'h3, 4'h2, 4'h1
  };

  function automatic key_idx_t key_at(input int p);
    return KEY_TABLE[p*4 +: 4];
  endfunction

endpackage
`default_nettype wire

// File: rtl/chip8_key_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : chip8_key_debounce                                              |
// | Purpose  : Debounce a single key from periodic scan samples.               |
// | Ports    : clk       - system clock                                        |
// |            reset_n   - synchronous active-low reset                        |
// |            sample_i  - one-cycle strobe: raw_i is a valid scan sample       |
// |            raw_i     - sampled key level (1 = pressed)                     |
// |            state_o   - debounced key level                                 |
// |            rise_o    - high in the sample cycle that makes state_o rise    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module chip8_key_debounce #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sample_i,
  input  logic raw_i,
  output logic state_o,
  output logic rise_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w_last;

  // This sample is the final disagreeing one needed to flip the state.
  assign w_last = (cnt_q == CNT_W'(DEBOUNCE_SCANS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (sample_i) begin
      if (raw_i == state_q) begin
        cnt_d = '0;
      end else if (w_last) begin
        state_d = ~state_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;
  assign rise_o  = sample_i & raw_i & ~state_q & w_last;

endmodule
`default_nettype wire

// File: rtl/chip8_keypad_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : chip8_keypad_scan                                               |
// | Purpose  : Scan a 4x4 matrix keypad, debounce each key and report the      |
// |            CHIP-8 key state plus a press event.                            |
// | Ports    : clk         - system clock, rising edge                         |
// |            reset_n     - synchronous active-low reset                      |
// |            col_out     - column drive, active-low, one bit low             |
// |            row_in      - row sense, active-low, asynchronous               |
// |            key_pressed - debounced state, bit k = key k held               |
// |            key_event   - one-cycle pulse when any key_pressed bit rises    |
// |            key_code    - lowest key that rose at the last key_event        |
// | Config   : KEYPAD_SYNC_EN - when defined, row_in passes through a 2-flop   |
// |            synchronizer before sampling.                                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module chip8_keypad_scan
  import chip8_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [3:0]  col_out,
  input  logic [3:0]  row_in,
  output logic [15:0] key_pressed,
  output logic        key_event,
  output logic [3:0]  key_code
);

  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [1:0]       col_q, col_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             event_q;
  key_idx_t         code_q;
  logic             w_sample;
  logic [3:0]       w_rows;
  logic [15:0]      w_pos_state, w_pos_rise;
  logic [15:0]      w_key_state, w_key_rise;
  logic             w_any_rise;
  key_idx_t         w_code;

`ifdef KEYPAD_SYNC_EN
  logic [3:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 4'b1111;
      sync2_q <= 4'b1111;
    end else begin
      sync1_q <= row_in;
      sync2_q <= sync1_q;
    end
  end

  assign w_rows = sync2_q;
`else
  assign w_rows = row_in;
`endif

  // The last divider cycle of a column is the sample cycle; its closing edge
  // updates the debouncers and advances the column together.
  assign w_sample = (div_q == DIV_W'(SCAN_DIV - 1));

  always_comb begin
    col_d = col_q;
    div_d = div_q + DIV_W'(1);
    if (w_sample) begin
      div_d = '0;
      col_d = col_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      col_q   <= 2'd0;
      div_q   <= '0;
      event_q <= 1'b0;
      code_q  <= '0;
    end else begin
      col_q   <= col_d;
      div_q   <= div_d;
      event_q <= w_any_rise;
      if (w_any_rise) begin
        code_q <= w_code;
      end
    end
  end

  assign col_out = ~(4'b0001 << col_q);

  // One debouncer per physical position; only the driven column samples.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      chip8_key_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
      ) u_db (
        .clk      (clk),
        .reset_n  (reset_n),
        .sample_i (w_sample && (col_q == 2'(c))),
        .raw_i    (~w_rows[r]),
        .state_o  (w_pos_state[r*4+c]),
        .rise_o   (w_pos_rise[r*4+c])
      );
    end
  end

  // Re-order from physical position to CHIP-8 key index.
  always_comb begin
    w_key_state = '0;
    w_key_rise  = '0;
    for (int p = 0; p < 16; p++) begin
      w_key_state[key_at(p)] = w_pos_state[p];
      w_key_rise[key_at(p)]  = w_pos_rise[p];
    end
  end

  // Priority to the lowest index: scan downward so the lowest hit wins.
  always_comb begin
    w_any_rise = |w_key_rise;
    w_code     = '0;
    for (int k = 15; k >= 0; k--) begin
      if (w_key_rise[k]) begin
        w_code = key_idx_t'(k);
      end
    end
  end

  assign key_pressed = w_key_state;
  assign key_event   = event_q;
  assign key_code    = code_q;

endmodule
`default_nettype wire

// File: tb/tb_chip8_keypad_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_chip8_keypad_scan                                            |
// | Purpose  : Self-checking bench for chip8_keypad_scan (SCAN_DIV=4,          |
// |            DEBOUNCE_SCANS=2). A keypad model drives row_in from col_out    |
// |            and the set of held keys; expected key codes are queued and    |
// |            popped whenever key_event is seen.                              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_chip8_keypad_scan;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  col_out;
  logic [3:0]  row_in;
  logic [15:0] key_pressed;
  logic        key_event;
  logic [3:0]  key_code;

  logic [15:0] held = '0;
  int          edge_n = 0;
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  exp_q[$];

  always #5 clk = ~clk;

  chip8_keypad_scan #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .col_out     (col_out),
    .row_in      (row_in),
    .key_pressed (key_pressed),
    .key_event   (key_event),
    .key_code    (key_code)
  );

  // Physical keypad: key at (row r, col c), rows top-down.
  function automatic int bench_key(input int r, input int c);
    int tbl [16];
    tbl = '{1, 2, 3, 12, 4, 5, 6, 13, 7, 8, 9, 14, 10, 0, 11, 15};
    return tbl[r*4 + c];
  endfunction

  always_comb begin
    row_in = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      if (!col_out[c]) begin
        for (int r = 0; r < 4; r++) begin
          if (held[bench_key(r, c)]) row_in[r] = 1'b0;
        end
      end
    end
  end

  // Scoreboard consumer: every event must match the oldest queued code.
  always @(negedge clk) begin
    if (reset_n && key_event) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: key_event=1 key_code=%0h, no event expected", key_code);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (key_code !== e) begin
          errors++;
          $display("FAIL event_code: key_code=%0h expected %0h", key_code, e);
        end
      end
    end
  end

  // Hold reset for two edges, release at a falling edge; edge_n counts
  // rising edges since release.
  task automatic do_reset();
    held = '0;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    edge_n = 0;
  endtask

  task automatic step_to(input int k);
    while (edge_n < k) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  task automatic check_queue_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected events never seen", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    held = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (col_out !== 4'b1110 || key_pressed !== 16'h0 || key_event !== 1'b0 || key_code !== 4'h0) begin
      errors++;
      $display("FAIL reset_values: col=%b kp=%h ev=%b code=%h expected 1110 0000 0 0",
               col_out, key_pressed, key_event, key_code);
    end
    @(negedge clk);
    reset_n = 1'b1;
    edge_n = 0;
    for (int k = 0; k < 32; k++) begin
      logic [3:0] exp_col;
      step_to(k);
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      checks++;
      if (col_out !== exp_col || key_pressed !== 16'h0) begin
        errors++;
        $display("FAIL scan_col[%0d]: col=%b kp=%h expected col=%b kp=0000",
                 k, col_out, key_pressed, exp_col);
      end
    end
    check_queue_empty("reset_no_event");
  endtask

  task automatic test_press_release();
    do_reset();
    held[5] = 1'b1;
    exp_q.push_back(4'h5);
    step_to(23);
    checks++;
    if (key_pressed !== 16'h0) begin
      errors++;
      $display("FAIL key5_early: kp=%h expected 0000", key_pressed);
    end
    step_to(24);
    checks++;
    if (key_pressed !== 16'h0020 || key_event !== 1'b1) begin
      errors++;
      $display("FAIL key5_press: kp=%h ev=%b expected 0020 1", key_pressed, key_event);
    end
    step_to(25);
    checks++;
    if (key_event !== 1'b0 || key_code !== 4'h5) begin
      errors++;
      $display("FAIL key5_pulse: ev=%b code=%h expected 0 5", key_event, key_code);
    end
    step_to(26);
    held[5] = 1'b0;
    step_to(55);
    checks++;
    if (key_pressed !== 16'h0020) begin
      errors++;
      $display("FAIL key5_release_early: kp=%h expected 0020", key_pressed);
    end
    step_to(56);
    checks++;
    if (key_pressed !== 16'h0 || key_code !== 4'h5) begin
      errors++;
      $display("FAIL key5_release: kp=%h code=%h expected 0000 5", key_pressed, key_code);
    end
    step_to(60);
    check_queue_empty("key5_events");
  endtask

  task automatic test_bounce();
    // Key 1 seen on column-0 samples at edges 4 and 36 but not 20.
    do_reset();
    held[1] = 1'b1;
    step_to(5);
    held[1] = 1'b0;
    step_to(32);
    held[1] = 1'b1;
    step_to(37);
    held[1] = 1'b0;
    checks++;
    if (key_pressed !== 16'h0) begin
      errors++;
      $display("FAIL bounce: kp=%h expected 0000", key_pressed);
    end
    step_to(56);
    checks++;
    if (key_pressed !== 16'h0) begin
      errors++;
      $display("FAIL bounce_late: kp=%h expected 0000", key_pressed);
    end
    check_queue_empty("bounce_events");
  endtask

  task automatic test_multi();
    do_reset();
    held[12] = 1'b1;
    held[15] = 1'b1;
    exp_q.push_back(4'hC);
    step_to(31);
    checks++;
    if (key_pressed !== 16'h0) begin
      errors++;
      $display("FAIL multi_early: kp=%h expected 0000", key_pressed);
    end
    step_to(32);
    checks++;
    if (key_pressed !== 16'h9000) begin
      errors++;
      $display("FAIL multi_state: kp=%h expected 9000", key_pressed);
    end
    step_to(40);
    checks++;
    if (key_code !== 4'hC) begin
      errors++;
      $display("FAIL multi_code: code=%h expected c", key_code);
    end
    check_queue_empty("multi_events");
  endtask

  task automatic test_reset_mid();
    do_reset();
    held[9] = 1'b1;
    step_to(14);
    checks++;
    if (key_pressed !== 16'h0) begin
      errors++;
      $display("FAIL key9_pre: kp=%h expected 0000", key_pressed);
    end
    reset_n = 1'b0;
    step_to(16);
    checks++;
    if (col_out !== 4'b1110 || key_pressed !== 16'h0 || key_event !== 1'b0 || key_code !== 4'h0) begin
      errors++;
      $display("FAIL mid_reset_values: col=%b kp=%h ev=%b code=%h expected 1110 0000 0 0",
               col_out, key_pressed, key_event, key_code);
    end
    reset_n = 1'b1;
    edge_n = 0;
    exp_q.push_back(4'h9);
    step_to(12);
    checks++;
    if (key_pressed !== 16'h0) begin
      errors++;
      $display("FAIL key9_fresh1: kp=%h expected 0000", key_pressed);
    end
    step_to(28);
    checks++;
    if (key_pressed !== 16'h0200) begin
      errors++;
      $display("FAIL key9_fresh2: kp=%h expected 0200", key_pressed);
    end
    step_to(32);
    checks++;
    if (key_code !== 4'h9) begin
      errors++;
      $display("FAIL key9_code: code=%h expected 9", key_code);
    end
    check_queue_empty("key9_events");
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_bounce();
    test_multi();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Backstop so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, limit 200000 expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
